bp_fe_bht_ctrl: RTL and testbench

Sequencer and arbiter for the front-end branch history table (BHT). It owns the single-port BHT SRAM and shares it between the fetch-stage prediction lookup and the backend's resolved-branch updates. Updates are buffered in a small queue and applied to the 2-bit saturating counters with a read-modify-write. After reset, the block sweeps the table to a known state. It sits between the branch-predictor wrapper (lookup/update requesters) and the BHT memory macro.

---
 rtl/bp_fe_pkg.sv | 19 +
 rtl/bp_fe_bht_upd_queue.sv | 52 +++++
 rtl/bp_fe_bht_ctrl.sv | 154 +++++++++++++++
 tb/tb_bp_fe_bht_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fe_pkg.sv
// Shared front-end branch-predictor types: BHT controller states, counter init value, update record.
package bp_fe_pkg;

    localparam int         bht_idx_width_gp = 3;
    localparam logic [1:0] bht_init_val_gp  = 2'b01;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        UPD_WR
    } bp_fe_bht_ctrl_state_e;

    // idx width is tied to bht_idx_width_gp; change both together when resizing the table.
    typedef struct packed {
        logic [bht_idx_width_gp-1:0] idx;
        logic                        taken;
    } bp_fe_bht_upd_s;

endpackage

// File: rtl/bp_fe_bht_upd_queue.sv
// Circular FIFO of resolved-branch updates waiting for a BHT read-modify-write slot.
module bp_fe_bht_upd_queue
    import bp_fe_pkg::*;
#(
    parameter int els_p = 4
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           v_i,
    output logic           ready_o,
    input  bp_fe_bht_upd_s data_i,
    output logic           v_o,
    input  logic           yumi_i,
    output bp_fe_bht_upd_s data_o,
    output logic           full_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [cnt_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_rd_ptr;
    bp_fe_bht_upd_s      r_mem [els_p];

    logic w_push;
    logic w_pop;

    assign full_o  = (r_wr_ptr[ptr_w_lp] != r_rd_ptr[ptr_w_lp])
                  && (r_wr_ptr[ptr_w_lp-1:0] == r_rd_ptr[ptr_w_lp-1:0]);
    assign v_o     = (r_wr_ptr != r_rd_ptr);
    assign ready_o = !full_o;
    assign data_o  = r_mem[r_rd_ptr[ptr_w_lp-1:0]];

    assign w_push = v_i & ready_o;
    assign w_pop  = yumi_i & v_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + cnt_w_lp'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[ptr_w_lp-1:0]] <= data_i;
    end

endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// BHT sequencer: arbitrates the single-port SRAM between lookups and queued counter RMWs.
// Define BP_FE_BHT_CTRL_INIT_SWEEP_EN to sweep the table to weakly-not-taken after reset.
module bp_fe_bht_ctrl
    import bp_fe_pkg::*;
#(
    parameter int bht_idx_width_p = bht_idx_width_gp,
    parameter int upd_fifo_els_p  = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    input  logic                       w_v_i,
    output logic                       w_ready_o,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       taken_i,
    output logic                       init_done_o,
    output logic                       mem_v_o,
    output logic                       mem_w_o,
    output logic [bht_idx_width_p-1:0] mem_addr_o,
    output logic [1:0]                 mem_data_o,
    input  logic [1:0]                 mem_data_i
);

    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    bp_fe_bht_ctrl_state_e r_state;
    bp_fe_bht_ctrl_state_e w_state_n;
    logic                  r_pred_v;

    logic                       w_mem_v;
    logic                       w_mem_w;
    logic [bht_idx_width_p-1:0] w_mem_addr;
    logic [1:0]                 w_mem_data;
    logic                       w_lookup_grant;

    logic                       w_q_ready;
    logic                       w_q_v;
    logic                       w_q_full;
    logic                       w_q_pop;
    logic                       w_q_push;
    bp_fe_bht_upd_s             w_q_in;
    bp_fe_bht_upd_s             w_q_head;

    logic [bht_idx_width_p-1:0] w_sweep_idx;
    logic                       w_sweep_last;

`ifdef BP_FE_BHT_CTRL_INIT_SWEEP_EN
    localparam int els_lp = 2 ** bht_idx_width_p;
    localparam bp_fe_bht_ctrl_state_e reset_state_lp = INIT;

    logic [bht_idx_width_p-1:0] r_sweep_idx;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)              r_sweep_idx <= '0;
        else if (r_state == INIT)  r_sweep_idx <= r_sweep_idx + bht_idx_width_p'(1);
    end

    assign w_sweep_idx  = r_sweep_idx;
    assign w_sweep_last = (r_sweep_idx == bht_idx_width_p'(els_lp - 1));
`else
    localparam bp_fe_bht_ctrl_state_e reset_state_lp = IDLE;

    assign w_sweep_idx  = '0;
    assign w_sweep_last = 1'b1;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= reset_state_lp;
            r_pred_v <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_pred_v <= w_lookup_grant;
        end
    end

    // A full queue takes the port ahead of lookups so updates can never starve.
    always_comb begin
        w_state_n      = r_state;
        w_mem_v        = 1'b0;
        w_mem_w        = 1'b0;
        w_mem_addr     = '0;
        w_mem_data     = '0;
        w_lookup_grant = 1'b0;
        w_q_pop        = 1'b0;
        case (r_state)
            INIT: begin
                w_mem_v    = 1'b1;
                w_mem_w    = 1'b1;
                w_mem_addr = w_sweep_idx;
                w_mem_data = bht_init_val_gp;
                if (w_sweep_last) w_state_n = IDLE;
            end
            IDLE: begin
                if (w_q_full && w_q_v) begin
                    w_mem_v    = 1'b1;
                    w_mem_addr = w_q_head.idx;
                    w_state_n  = UPD_WR;
                end else if (r_v_i) begin
                    w_mem_v        = 1'b1;
                    w_mem_addr     = idx_r_i;
                    w_lookup_grant = 1'b1;
                end else if (w_q_v) begin
                    w_mem_v    = 1'b1;
                    w_mem_addr = w_q_head.idx;
                    w_state_n  = UPD_WR;
                end
            end
            UPD_WR: begin
                w_mem_v    = 1'b1;
                w_mem_w    = 1'b1;
                w_mem_addr = w_q_head.idx;
                w_mem_data = sat_update(mem_data_i, w_q_head.taken);
                w_q_pop    = 1'b1;
                w_state_n  = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    assign init_done_o = reset_i & (r_state != INIT);
    assign w_ready_o   = init_done_o & w_q_ready;
    assign w_q_push    = w_v_i & w_ready_o;
    assign w_q_in      = '{idx: idx_w_i, taken: taken_i};

    assign mem_v_o     = w_mem_v & reset_i;
    assign mem_w_o     = w_mem_w;
    assign mem_addr_o  = w_mem_addr;
    assign mem_data_o  = w_mem_data;

    assign predict_v_o = r_pred_v;
    assign predict_o   = r_pred_v & mem_data_i[1];

    bp_fe_bht_upd_queue #(
        .els_p(upd_fifo_els_p)
    ) u_upd_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (w_q_push),
        .ready_o (w_q_ready),
        .data_i  (w_q_in),
        .v_o     (w_q_v),
        .yumi_i  (w_q_pop),
        .data_o  (w_q_head),
        .full_o  (w_q_full)
    );

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Directed bench for bp_fe_bht_ctrl with a behavioural single-port BHT SRAM.
// Covers both builds of BP_FE_BHT_CTRL_INIT_SWEEP_EN.
module tb_bp_fe_bht_ctrl;

    localparam int W   = 3;
    localparam int ELS = 8;

    logic         clk;
    logic         reset_i;
    logic         r_v_i;
    logic [W-1:0] idx_r_i;
    logic         predict_v_o;
    logic         predict_o;
    logic         w_v_i;
    logic         w_ready_o;
    logic [W-1:0] idx_w_i;
    logic         taken_i;
    logic         init_done_o;
    logic         mem_v_o;
    logic         mem_w_o;
    logic [W-1:0] mem_addr_o;
    logic [1:0]   mem_data_o;
    logic [1:0]   mem_data_i;

    logic [1:0]   sram [ELS];
    int           n_checks;
    int           n_pass;

    bp_fe_bht_ctrl #(
        .bht_idx_width_p(W),
        .upd_fifo_els_p (4)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .r_v_i       (r_v_i),
        .idx_r_i     (idx_r_i),
        .predict_v_o (predict_v_o),
        .predict_o   (predict_o),
        .w_v_i       (w_v_i),
        .w_ready_o   (w_ready_o),
        .idx_w_i     (idx_w_i),
        .taken_i     (taken_i),
        .init_done_o (init_done_o),
        .mem_v_o     (mem_v_o),
        .mem_w_o     (mem_w_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_v_o) begin
            if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
            else         mem_data_i       <= sram[mem_addr_o];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic expect_port(input string tag, input logic v, input logic w,
                               input logic [W-1:0] addr, input logic [1:0] data);
        check({tag, "_v"}, mem_v_o, v);
        if (v) begin
            check({tag, "_w"}, mem_w_o, w);
            check({tag, "_addr"}, mem_addr_o, addr);
            if (w) check({tag, "_data"}, mem_data_o, data);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #2;
    endtask

    // One update through an otherwise idle port: enqueue, RMW read, RMW write.
    task automatic rmw(input string tag, input logic [W-1:0] idx, input logic taken,
                       input logic [1:0] exp_data);
        cyc(); w_v_i = 1'b1; idx_w_i = idx; taken_i = taken; settle();
        check({tag, "_enq_idle"}, mem_v_o, 1'b0);
        cyc(); w_v_i = 1'b0; settle();
        expect_port({tag, "_rd"}, 1'b1, 1'b0, idx, 2'b00);
        cyc(); settle();
        expect_port({tag, "_wr"}, 1'b1, 1'b1, idx, exp_data);
    endtask

`ifdef BP_FE_BHT_CTRL_INIT_SWEEP_EN
    // Called in the first cycle after reset release.
    task automatic sweep_check(input string tag);
        for (int i = 0; i < ELS; i++) begin
            expect_port($sformatf("%s_sw%0d", tag, i), 1'b1, 1'b1, W'(i), 2'b01);
            check($sformatf("%s_busy%0d", tag, i), {init_done_o, w_ready_o}, 2'b00);
            cyc(); settle();
        end
        check({tag, "_done"}, init_done_o, 1'b1);
        check({tag, "_ready"}, w_ready_o, 1'b1);
        check({tag, "_quiet"}, mem_v_o, 1'b0);
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_i  = 1'b0;
        r_v_i    = 1'b0;
        w_v_i    = 1'b0;
        taken_i  = 1'b0;
        idx_r_i  = '0;
        idx_w_i  = '0;
        for (int i = 0; i < ELS; i++) begin
`ifdef BP_FE_BHT_CTRL_INIT_SWEEP_EN
            sram[i] = 2'b11;
`else
            sram[i] = 2'b01;
`endif
        end

        cyc(); r_v_i = 1'b1; settle();
        check("rst_init_done", init_done_o, 1'b0);
        check("rst_w_ready", w_ready_o, 1'b0);
        check("rst_predict_v", predict_v_o, 1'b0);
        check("rst_predict", predict_o, 1'b0);
        check("rst_mem_v", mem_v_o, 1'b0);

        cyc(); r_v_i = 1'b0; reset_i = 1'b1; settle();
`ifdef BP_FE_BHT_CTRL_INIT_SWEEP_EN
        sweep_check("init");
`else
        check("noinit_done", init_done_o, 1'b1);
        check("noinit_ready", w_ready_o, 1'b1);
        check("noinit_quiet", mem_v_o, 1'b0);
`endif

        cyc(); r_v_i = 1'b1; idx_r_i = 3'd2; settle();
        expect_port("lk2_rd", 1'b1, 1'b0, 3'd2, 2'b00);
        cyc(); r_v_i = 1'b0; settle();
        check("lk2_predict_v", predict_v_o, 1'b1);
        check("lk2_predict", predict_o, 1'b0);

        cyc(); w_v_i = 1'b1; idx_w_i = 3'd5; taken_i = 1'b1; settle();
        check("t5_ready", w_ready_o, 1'b1);
        check("t5_enq_idle", mem_v_o, 1'b0);
        cyc(); settle();
        expect_port("t5_rd1", 1'b1, 1'b0, 3'd5, 2'b00);
        cyc(); w_v_i = 1'b0; settle();
        expect_port("t5_wr1", 1'b1, 1'b1, 3'd5, 2'b10);
        cyc(); settle();
        expect_port("t5_rd2", 1'b1, 1'b0, 3'd5, 2'b00);
        cyc(); settle();
        expect_port("t5_wr2", 1'b1, 1'b1, 3'd5, 2'b11);
        cyc(); r_v_i = 1'b1; idx_r_i = 3'd5; settle();
        expect_port("lk5_rd", 1'b1, 1'b0, 3'd5, 2'b00);
        cyc(); r_v_i = 1'b0; settle();
        check("lk5_predict_v", predict_v_o, 1'b1);
        check("lk5_predict", predict_o, 1'b1);

        rmw("nt1_a", 3'd1, 1'b0, 2'b00);
        rmw("nt1_b", 3'd1, 1'b0, 2'b00);
        rmw("nt1_c", 3'd1, 1'b0, 2'b00);

        // Lookup held high while four updates fill the queue.
        cyc(); r_v_i = 1'b1; idx_r_i = 3'd3; w_v_i = 1'b1; idx_w_i = 3'd6; taken_i = 1'b1; settle();
        check("fq_c0_ready", w_ready_o, 1'b1);
        expect_port("fq_c0", 1'b1, 1'b0, 3'd3, 2'b00);
        cyc(); idx_w_i = 3'd7; taken_i = 1'b1; settle();
        check("fq_c1_ready", w_ready_o, 1'b1);
        check("fq_c1_predict_v", predict_v_o, 1'b1);
        expect_port("fq_c1", 1'b1, 1'b0, 3'd3, 2'b00);
        cyc(); idx_w_i = 3'd7; taken_i = 1'b1; settle();
        check("fq_c2_ready", w_ready_o, 1'b1);
        expect_port("fq_c2", 1'b1, 1'b0, 3'd3, 2'b00);
        cyc(); idx_w_i = 3'd0; taken_i = 1'b0; settle();
        check("fq_c3_ready", w_ready_o, 1'b1);
        expect_port("fq_c3", 1'b1, 1'b0, 3'd3, 2'b00);
        cyc(); w_v_i = 1'b0; settle();
        check("fq_c4_full", w_ready_o, 1'b0);
        check("fq_c4_predict_v", predict_v_o, 1'b1);
        expect_port("fq_c4_preempt", 1'b1, 1'b0, 3'd6, 2'b00);
        cyc(); settle();
        check("fq_c5_full", w_ready_o, 1'b0);
        check("fq_c5_predict_v", predict_v_o, 1'b0);
        expect_port("fq_c5_wr", 1'b1, 1'b1, 3'd6, 2'b10);
        cyc(); settle();
        check("fq_c6_ready", w_ready_o, 1'b1);
        check("fq_c6_predict_v", predict_v_o, 1'b0);
        expect_port("fq_c6_lk", 1'b1, 1'b0, 3'd3, 2'b00);
        cyc(); r_v_i = 1'b0; settle();
        check("fq_c7_predict_v", predict_v_o, 1'b1);
        check("fq_c7_predict", predict_o, 1'b0);
        expect_port("fq_c7_rd", 1'b1, 1'b0, 3'd7, 2'b00);
        cyc(); settle();
        expect_port("fq_c8_wr", 1'b1, 1'b1, 3'd7, 2'b10);
        cyc(); settle();
        expect_port("fq_c9_rd", 1'b1, 1'b0, 3'd7, 2'b00);
        cyc(); settle();
        expect_port("fq_c10_wr", 1'b1, 1'b1, 3'd7, 2'b11);
        cyc(); settle();
        expect_port("fq_c11_rd", 1'b1, 1'b0, 3'd0, 2'b00);
        cyc(); settle();
        expect_port("fq_c12_wr", 1'b1, 1'b1, 3'd0, 2'b00);
        cyc(); settle();
        check("fq_drained", mem_v_o, 1'b0);

        // Reset lands in the write half of an RMW; the write must be dropped.
        cyc(); w_v_i = 1'b1; idx_w_i = 3'd4; taken_i = 1'b1; settle();
        check("mr_enq_idle", mem_v_o, 1'b0);
        cyc(); w_v_i = 1'b0; settle();
        expect_port("mr_rd", 1'b1, 1'b0, 3'd4, 2'b00);
        cyc(); reset_i = 1'b0; settle();
        check("mr_rst_mem_v", mem_v_o, 1'b0);
        check("mr_rst_init_done", init_done_o, 1'b0);
        check("mr_rst_ready", w_ready_o, 1'b0);
        check("mr_rst_predict_v", predict_v_o, 1'b0);
        cyc(); reset_i = 1'b1; settle();
`ifdef BP_FE_BHT_CTRL_INIT_SWEEP_EN
        sweep_check("mr_resweep");
`else
        check("mr_done", init_done_o, 1'b1);
        check("mr_ready", w_ready_o, 1'b1);
        check("mr_q_empty0", mem_v_o, 1'b0);
        cyc(); settle();
        check("mr_q_empty1", mem_v_o, 1'b0);
`endif
        cyc(); r_v_i = 1'b1; idx_r_i = 3'd4; settle();
        expect_port("mr_lk4_rd", 1'b1, 1'b0, 3'd4, 2'b00);
        cyc(); r_v_i = 1'b0; settle();
        check("mr_lk4_predict_v", predict_v_o, 1'b1);
        check("mr_lk4_predict", predict_o, 1'b0);

`ifdef BP_FE_BHT_CTRL_INIT_SWEEP_EN
        // Reset when the sweep reaches index 4; it must restart from 0.
        cyc(); reset_i = 1'b0; settle();
        check("mi_rst_mem_v", mem_v_o, 1'b0);
        cyc(); reset_i = 1'b1; settle();
        for (int i = 0; i < 4; i++) begin
            expect_port($sformatf("mi_pre%0d", i), 1'b1, 1'b1, W'(i), 2'b01);
            cyc(); settle();
        end
        expect_port("mi_at4", 1'b1, 1'b1, 3'd4, 2'b01);
        cyc(); reset_i = 1'b0; settle();
        check("mi_rst_mem_v4", mem_v_o, 1'b0);
        check("mi_rst_done", init_done_o, 1'b0);
        cyc(); reset_i = 1'b1; settle();
        sweep_check("mi_resweep");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
